// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC register and IF/ID pipeline
// register. Next PC comes from sequential, branch, jump or jump-register
// selection; redirects resolve in ID, so the instruction currently in IF is
// the delay slot and is loaded into IF/ID normally.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   stall               hold PC, IF/ID and fetch counter
//   clr                 load a bubble into IF/ID (PC still follows stall)
//   npc_sel             00 seq, 01 branch, 10 jump, 11 jump register
//   br_taken, imm16     branch condition and offset from ID
//   j_index             jump index from ID
//   jr_target           forwarded rs value for jr/jalr
//   instr_i             instruction memory data for pc_o
//   pc_o                current fetch PC (always word aligned)
//   ifid_instr/pc/pc8   IF/ID instruction, its PC, and PC+8 link value
//   ifid_valid          IF/ID holds a real instruction
//   adel_o              sticky misaligned jr target flag
//   fetch_cnt           number of instructions loaded into IF/ID
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clr,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc8,
  output logic        ifid_valid,
  output logic        adel_o,
  output logic [31:0] fetch_cnt
);

  // The PC is held as a word address so alignment is structural.
  logic [31:2] pc_q, pc_d, npc;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;
  logic [31:0] cnt_q, cnt_d;

  // Word-address next-PC: the branch offset is already a word count.
  always_comb begin
    npc = pc_q + 30'd1;
    unique case (npc_sel)
      2'b01:   if (br_taken) npc = ipc_q[31:2] + 30'd1 + {{14{imm16[15]}}, imm16};
      2'b10:   npc = {ipc_q[31:28], j_index};
      2'b11:   npc = jr_target[31:2];
      default: npc = pc_q + 30'd1;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    cnt_d   = cnt_q;

    // PC motion depends only on stall; clr affects IF/ID alone.
    if (!stall) begin
      pc_d = npc;
      if (npc_sel == 2'b11 && jr_target[1:0] != 2'b00) adel_d = 1'b1;
    end

    if (clr) begin
      instr_d = '0;
      ipc_d   = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = instr_i;
      ipc_d   = {pc_q, 2'b00};
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC[31:2];
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o       = {pc_q, 2'b00};
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_pc8   = ipc_q + 32'd8;
  assign ifid_valid = valid_q;
  assign adel_o     = adel_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard stall from the ID stage.
REQ-005 clr  input  1  IF/ID clear; the register is loaded with a bubble.
REQ-006 npc_sel  input  2  00 sequential, 01 branch, 10 jump (j/jal), 11 jump register.
REQ-007 br_taken  input  1  branch condition resolved in ID.
REQ-008 imm16  input  16  branch offset of the instruction in ID.
REQ-009 j_index  input  26  jump index of the instruction in ID.
REQ-010 jr_target  input  32  forwarded rs value for jr/jalr.
REQ-011 instr_i  input  32  instruction word returned combinationally by instruction memory for pc_o.
REQ-012 pc_o  output  32  current fetch PC, driven to instruction memory.
REQ-013 ifid_instr  output  32  registered instruction for ID.
REQ-014 ifid_pc  output  32  registered PC of ifid_instr.
REQ-015 ifid_pc8  output  32  ifid_pc+8, the jal/jalr link value.
REQ-016 ifid_valid  output  1  ifid_instr is a real fetched instruction, not a bubble.
REQ-017 adel_o  output  1  sticky misaligned jr target flag.
REQ-018 fetch_cnt  output  32  count of instructions loaded into IF/ID.

Function
REQ-019 All arithmetic SHALL be 32-bit modulo 2^32; overflow wraps silently.
REQ-020 Branch target SHALL be ifid_pc + 4 + (sign-extended imm16 << 2).
REQ-021 Jump target SHALL be {ifid_pc[31:28], j_index, 2'b00}.
REQ-022 JR target SHALL be {jr_target[31:2], 2'b00}.
REQ-023 Next PC SHALL be:
  - pc_o+4 when npc_sel=00, or npc_sel=01 with br_taken=0;
  - the branch target for npc_sel=01 with br_taken=1;
  - the jump target for 10;
  - the JR target for 11.
REQ-024 The instruction in IF during a redirect is the delay slot; it SHALL be loaded into IF/ID normally, and redirect takes effect on the PC only.
REQ-025 When stall=1 and clr=0, pc_o, the IF/ID registers and fetch_cnt SHALL hold, and the redirect inputs SHALL be ignored.
REQ-026 When stall=0 and clr=0, the edge SHALL:
  - load PC with the next PC;
  - load ifid_instr with instr_i, ifid_pc with pc_o, and ifid_valid with 1;
  - increment fetch_cnt.
REQ-027 When clr=1, the IF/ID registers SHALL load instr 32'h0, pc 32'h0 and valid 0, regardless of stall; fetch_cnt SHALL NOT increment.
REQ-028 When clr=1 and stall=1 together, the PC SHALL hold; with clr=1 and stall=0, the PC SHALL advance per REQ-023.
REQ-029 ifid_pc8 SHALL be combinational ifid_pc+8 (wraps).
REQ-030 adel_o SHALL set on any non-stalled edge where npc_sel=11 and jr_target[1:0]!=0, and SHALL remain 1 until reset.
REQ-031 pc_o SHALL always be word-aligned (bits [1:0]=00).
REQ-032 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-033 On reset assertion, immediately and independent of clk, the block SHALL force:
  - pc_o=RESET_PC;
  - ifid_instr=0, ifid_pc=0, ifid_valid=0;
  - adel_o=0, fetch_cnt=0.
REQ-034 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; the first rising edge after deassertion SHALL fetch RESET_PC.

Verification
REQ-035 The bench SHALL cover:
  - Reset, then 3 free-running edges -> pc_o 3000, 3004, 3008, 300C; ifid_pc 3000, 3004, 3008; fetch_cnt=3.
  - Branch: ifid_pc=3004, npc_sel=01, br_taken=1, imm16=16'hFFFF, pc_o=3008 -> next pc_o=3004; with br_taken=0 -> next pc_o=300C.
  - Jump and jr: ifid_pc=3010, j_index=26'h0000C40 -> pc_o=00003100; jr_target=32'h00003022 -> pc_o=00003020 and adel_o=1, held until reset.
  - Stall for 2 cycles with npc_sel=10 applied -> pc_o, ifid_* and fetch_cnt unchanged; redirect ignored; advance resumes after stall drops.
  - clr=1 with stall=1 -> ifid_valid=0, ifid_instr=0, pc_o held, fetch_cnt unchanged.
  - Wrap: force pc_o=FFFF_FFFC sequential -> pc_o=0000_0000; ifid_pc8 of FFFF_FFFC -> 0000_0004.
  - Async reset pulse between edges -> outputs reset before the next edge.
